// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width, line rate.
// The state encodings, byte width and line rate that used to sit in the shared header are defined here.
package uart_tx_arbiter_pkg;

  localparam int unsigned BAUD_RATE = 9600;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or after ptr, wrapping.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = ptr;
    idx    = ptr;
    // Scan from the farthest offset inward so the nearest pending index wins last.
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = IDX_W'((32'(ptr) + k - 1) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters with round-robin grants and a start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_send,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             any;
  logic [CNT_W-1:0] cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      req_ack  <= '0;
      tx_data  <= '0;
      tx_send  <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          // tx_ready low here means a frame from before rst is still on the line.
          if (any && tx_ready) begin
            tx_data  <= req_data[BYTE_W*winner +: BYTE_W];
            grant_id <= winner;
            tx_send  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_ready) begin
            tx_send <= 1'b0;
            state   <= ST_WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            // Abort without ack and leave ptr alone so the same requester is retried.
            tx_send <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            req_ack[grant_id] <= 1'b1;
            state             <= ST_ACK;
          end
        end
        ST_ACK: begin
          ptr   <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model (shortened bit time).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int          BIT_CYC = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     hold = '0;
  logic [8*NUM_REQ-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]     req_ack;
  logic [7:0]             tx_data;
  logic                   tx_send;
  logic                   tx_ready = 1'b1;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   err;
  logic                   model_en = 1'b1;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err)
  );

  always #41.667 clk = ~clk;

  // Behavioural uart_tx: starts on send while ready, drives start/8 data/stop, reads tx_data live.
  logic       m_busy = 1'b0;
  int         m_bit = 0, m_cyc = 0, m_starts = 0, m_glitch = 0;
  logic [7:0] m_first = '0;
  logic [9:0] m_rec = '0, m_last = '0;
  logic [2:0] m_sel;
  logic       line;
  int         m_byte_q[$];

  assign m_sel = 3'(m_bit - 1);
  assign line  = !m_busy ? 1'b1 : (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : tx_data[m_sel];

  always @(posedge clk) begin
    if (!m_busy) begin
      if (model_en && tx_send) begin
        m_busy   <= 1'b1;
        tx_ready <= 1'b0;
        m_bit    <= 0;
        m_cyc    <= 0;
        m_starts <= m_starts + 1;
        m_first  <= tx_data;
      end
    end else begin
      if (tx_data != m_first) m_glitch <= m_glitch + 1;
      if (m_cyc == BIT_CYC / 2) m_rec[m_bit] <= line;
      if (m_cyc == BIT_CYC - 1) begin
        m_cyc <= 0;
        if (m_bit == 9) begin
          m_busy   <= 1'b0;
          tx_ready <= 1'b1;
          m_last   <= m_rec;
          m_byte_q.push_back(int'(m_rec[8:1]));
        end else begin
          m_bit <= m_bit + 1;
        end
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end
  end

  // Event monitor: grant order at tx_send rise, ack order, ack pulse shape, send/ready overlap.
  int                 ack_q[$];
  int                 grant_q[$];
  int                 ack_bad = 0, overlap = 0;
  logic               prev_send = 1'b0;
  logic [NUM_REQ-1:0] prev_ack = '0;

  always @(negedge clk) begin
    prev_send <= tx_send;
    prev_ack  <= req_ack;
    if (tx_send && !prev_send) grant_q.push_back(int'(grant_id));
    if (req_ack != '0) begin
      if (!$onehot(req_ack) || prev_ack != '0) ack_bad <= ack_bad + 1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) ack_q.push_back(i);
    end
    if (tx_send && !tx_ready) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Acts as the requesters: drop valid on ack unless held; everything drops at the n-th ack.
  task automatic serve(input string tag, input int n, input int budget);
    int got = 0;
    int c   = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (req_ack != '0) begin
        got++;
        if (got == n) req_valid = '0;
        else          req_valid = req_valid & ~(req_ack & ~hold);
      end
    end
    check(tag, got, n);
  endtask

  int exp_rr[5]   = '{0, 1, 2, 3, 0};
  int exp_rrb[5]  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
  int exp_fair[4] = '{0, 2, 0, 2};

  initial begin
    int ba, bg, bb, n, c, g0, bad;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", req_ack, 0);
    check("rst_data", tx_data, 0);
    check("rst_send", tx_send, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // 1: single request, 0x55 on the line
    ba = ack_q.size(); bg = grant_q.size();
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    @(negedge clk);
    check("t1_send_latency", tx_send, 1);
    check("t1_grant", grant_id, 0);
    check("t1_data", tx_data, 8'h55);
    check("t1_busy", busy, 1);
    serve("t1_ack_seen", 1, 200);
    @(negedge clk);
    check("t1_serial", m_last, 10'h2AA);
    check("t1_ack_count", ack_q.size() - ba, 1);
    check("t1_ack_id", q_at(ack_q, ba), 0);
    check("t1_grant_q", q_at(grant_q, bg), 0);

    // 2: all four pending from reset, requester 0 re-requests
    do_reset();
    ba = ack_q.size(); bg = grant_q.size(); bb = m_byte_q.size();
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    hold      = 4'b0001;
    req_valid = 4'b1111;
    serve("t2_acks_seen", 5, 600);
    hold = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_ack%0d", i), q_at(ack_q, ba + i), exp_rr[i]);
      check($sformatf("t2_grant%0d", i), q_at(grant_q, bg + i), exp_rr[i]);
      check($sformatf("t2_byte%0d", i), q_at(m_byte_q, bb + i), exp_rrb[i]);
    end

    // 3: fairness between held requesters 0 and 2
    do_reset();
    ba = ack_q.size();
    req_data  = {8'h00, 8'h12, 8'h00, 8'h10};
    hold      = 4'b0101;
    req_valid = 4'b0101;
    serve("t3_acks_seen", 4, 600);
    hold = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_ack%0d", i), q_at(ack_q, ba + i), exp_fair[i]);

    // 4: transmitter never answers -> timeout, err, retry of the same requester
    do_reset();
    model_en = 1'b0;
    ba = ack_q.size();
    req_data[15:8] = 8'h7E;
    req_valid      = 4'b0010;
    c = 0;
    while (!tx_send && c < 10) begin @(negedge clk); c++; end
    n = 0;
    while (tx_send && n < 200) begin n++; @(negedge clk); end
    check("t4_send_cycles", n, 64);
    check("t4_err", err, 1);
    check("t4_busy_idle", busy, 0);
    c = 0;
    while (!tx_send && c < 5) begin @(negedge clk); c++; end
    check("t4_regrant_send", tx_send, 1);
    check("t4_regrant_id", grant_id, 1);
    check("t4_no_ack_yet", ack_q.size() - ba, 0);
    model_en = 1'b1;
    serve("t4_ack_seen", 1, 200);
    @(negedge clk);
    check("t4_ack_id", q_at(ack_q, ba), 1);
    check("t4_err_sticky", err, 1);

    // 5: reset while the transmitter is on data bit 3
    do_reset();
    check("t5_err_cleared", err, 0);
    ba = ack_q.size();
    req_data[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    c = 0;
    while (!(m_busy && m_bit == 4) && c < 100) begin @(negedge clk); c++; end
    check("t5_reached_bit3", m_bit, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_send_low", tx_send, 0);
    check("t5_busy_low", busy, 0);
    check("t5_ack_low", req_ack, 0);
    bad = 0; c = 0;
    while (!tx_ready && c < 100) begin
      if (tx_send || busy || req_ack != '0) bad++;
      @(negedge clk);
      c++;
    end
    check("t5_blocked_while_busy", bad, 0);
    check("t5_frame_ended", tx_ready, 1);
    serve("t5_ack_seen", 1, 200);
    @(negedge clk);
    check("t5_ack_count", ack_q.size() - ba, 1);
    check("t5_ack_id", q_at(ack_q, ba), 2);

    // 6: requester 3 drops valid and changes data mid-frame
    ba = ack_q.size(); bb = m_byte_q.size(); g0 = m_glitch;
    req_data[31:24] = 8'hC3;
    req_valid       = 4'b1000;
    c = 0;
    while (!(busy && !tx_send && !tx_ready) && c < 50) begin @(negedge clk); c++; end
    check("t6_in_wait_done", busy && !tx_send && !tx_ready, 1);
    check("t6_data_at_wait", tx_data, 8'hC3);
    req_valid[3]    = 1'b0;
    req_data[31:24] = 8'hFF;
    serve("t6_ack_seen", 1, 200);
    @(negedge clk);
    check("t6_ack_id", q_at(ack_q, ba), 3);
    check("t6_byte", q_at(m_byte_q, bb), 8'hC3);
    check("t6_data_stable", m_glitch - g0, 0);
    check("t6_data_held", tx_data, 8'hC3);

    // Whole-run properties
    @(negedge clk);
    check("ack_pulse_shape", ack_bad, 0);
    check("send_overlap", overlap, m_starts);
    check("frame_count", m_starts, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
